// File: rtl/mem_bus_scheduler.sv
// Round-robin owner of the shared memory bus.
// One requester at a time, held until the slave answers or the watchdog fires.
module mem_bus_scheduler #(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*NUM_PORTS-1:0]   req_address_in,
    input  logic [NUM_PORTS-1:0]      req_read_in,
    input  logic [NUM_PORTS-1:0]      req_write_in,
    input  logic [4*NUM_PORTS-1:0]    req_write_mask_in,
    input  logic [32*NUM_PORTS-1:0]   req_write_value_in,
    output logic [31:0]               req_read_value_out,
    output logic [NUM_PORTS-1:0]      req_ready_out,
    output logic [NUM_PORTS-1:0]      req_fault_out,
    output logic [31:0]               address_out,
    output logic                      read_out,
    output logic                      write_out,
    output logic [3:0]                write_mask_out,
    output logic [31:0]               write_value_out,
    input  logic [31:0]               read_value_in,
    input  logic                      ready_in,
    input  logic                      fault_in,
    output logic [NUM_PORTS-1:0]      grant_out,
    output logic                      busy_out
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   p_q, p_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic [NUM_PORTS-1:0] req_active;
    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [IW-1:0]        sel;
    int                   idx;
    logic [IW-1:0]        g_next;

    logic [31:0]          g_addr;
    logic                 g_rd;
    logic                 g_wr;
    logic [3:0]           g_mask;
    logic [31:0]          g_val;
    logic                 g_act;
    logic [NUM_PORTS-1:0] g_onehot;

    assign req_active = req_read_in | req_write_in;
    assign g_next     = (g_q == LAST_PORT) ? '0 : g_q + IW'(1);

    // First requesting port at or after the pointer, wrapping upward.
    always_comb begin
        pick     = p_q;
        pick_vld = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(p_q) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            sel = IW'(idx);
            if (req_active[sel]) begin
                pick     = sel;
                pick_vld = 1'b1;
            end
        end
    end

    // Mux out the granted port's request fields.
    always_comb begin
        g_addr   = '0;
        g_rd     = 1'b0;
        g_wr     = 1'b0;
        g_mask   = '0;
        g_val    = '0;
        g_act    = 1'b0;
        g_onehot = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (g_q == IW'(k)) begin
                g_addr      = req_address_in[k*32 +: 32];
                g_rd        = req_read_in[k];
                g_wr        = req_write_in[k];
                g_mask      = req_write_mask_in[k*4 +: 4];
                g_val       = req_write_value_in[k*32 +: 32];
                g_act       = req_active[k];
                g_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and bus outputs; the bus is dark whenever nobody owns it.
    always_comb begin
        state_d            = state_q;
        g_d                = g_q;
        p_d                = p_q;
        wd_d               = wd_q;
        req_read_value_out = '0;
        req_ready_out      = '0;
        req_fault_out      = '0;
        address_out        = '0;
        read_out           = 1'b0;
        write_out          = 1'b0;
        write_mask_out     = '0;
        write_value_out    = '0;
        grant_out          = '0;
        busy_out           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    g_d     = pick;
                    wd_d    = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy_out           = 1'b1;
                grant_out          = g_onehot;
                address_out        = g_addr;
                read_out           = g_rd;
                write_out          = g_wr;
                write_mask_out     = g_mask;
                write_value_out    = g_val;
                req_read_value_out = read_value_in;
                if (ready_in) begin
                    req_ready_out = g_onehot;
                    req_fault_out = fault_in ? g_onehot : '0;
                    p_d           = g_next;
                    state_d       = IDLE;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    req_ready_out = g_onehot;
                    req_fault_out = g_onehot;
                    p_d           = g_next;
                    state_d       = IDLE;
                end else if (!g_act) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
        endcase
    end

    // State registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Bench for mem_bus_scheduler: directed scenarios then random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_bus_scheduler;

    localparam int N  = 3;
    localparam int TO = 4;

    logic            clk;
    logic            reset;
    logic [32*N-1:0] req_address_in;
    logic [N-1:0]    req_read_in;
    logic [N-1:0]    req_write_in;
    logic [4*N-1:0]  req_write_mask_in;
    logic [32*N-1:0] req_write_value_in;
    logic [31:0]     req_read_value_out;
    logic [N-1:0]    req_ready_out;
    logic [N-1:0]    req_fault_out;
    logic [31:0]     address_out;
    logic            read_out;
    logic            write_out;
    logic [3:0]      write_mask_out;
    logic [31:0]     write_value_out;
    logic [31:0]     read_value_in;
    logic            ready_in;
    logic            fault_in;
    logic [N-1:0]    grant_out;
    logic            busy_out;

    logic [31:0] t_addr [N];
    logic        t_rd   [N];
    logic        t_wr   [N];
    logic [3:0]  t_mask [N];
    logic [31:0] t_val  [N];

    int          m_busy;
    int          m_g;
    int          m_p;
    int          m_wd;
    logic [2:0]  last_rdy;
    int          checks;
    int          errors;
    logic [2:0]  gseq[$];
    logic [2:0]  fexp [4];

    mem_bus_scheduler #(.NUM_PORTS(N), .TIMEOUT(TO)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_address_in     (req_address_in),
        .req_read_in        (req_read_in),
        .req_write_in       (req_write_in),
        .req_write_mask_in  (req_write_mask_in),
        .req_write_value_in (req_write_value_in),
        .req_read_value_out (req_read_value_out),
        .req_ready_out      (req_ready_out),
        .req_fault_out      (req_fault_out),
        .address_out        (address_out),
        .read_out           (read_out),
        .write_out          (write_out),
        .write_mask_out     (write_mask_out),
        .write_value_out    (write_value_out),
        .read_value_in      (read_value_in),
        .ready_in           (ready_in),
        .fault_in           (fault_in),
        .grant_out          (grant_out),
        .busy_out           (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_address_in     = '0;
        req_read_in        = '0;
        req_write_in       = '0;
        req_write_mask_in  = '0;
        req_write_value_in = '0;
        for (int k = 0; k < N; k++) begin
            req_address_in[k*32 +: 32]     = t_addr[k];
            req_read_in[k]                 = t_rd[k];
            req_write_in[k]                = t_wr[k];
            req_write_mask_in[k*4 +: 4]    = t_mask[k];
            req_write_value_in[k*32 +: 32] = t_val[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_g      = 0;
        m_p      = 0;
        m_wd     = 0;
        last_rdy = '0;
    endtask

    task automatic set_port(input int i, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] v);
        t_rd[i]   = rd;
        t_wr[i]   = wr;
        t_addr[i] = a;
        t_mask[i] = m;
        t_val[i]  = v;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            set_port(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
    endtask

    // Compare every output against what the model says this cycle holds.
    task automatic settle_check(input string tag);
        logic [31:0] ea, ev;
        logic        er, ew;
        logic [3:0]  em;
        logic [2:0]  eg, erd, ef, one;
        @(negedge clk);
        one = 3'b001;
        ea = '0; ev = '0; er = 1'b0; ew = 1'b0; em = '0;
        eg = '0; erd = '0; ef = '0;
        if (m_busy != 0) begin
            ea = t_addr[m_g];
            er = t_rd[m_g];
            ew = t_wr[m_g];
            em = t_mask[m_g];
            ev = t_val[m_g];
            eg = one << m_g;
            if (ready_in) begin
                erd = one << m_g;
                ef  = fault_in ? (one << m_g) : 3'b000;
            end else if (m_wd == TO - 1) begin
                erd = one << m_g;
                ef  = one << m_g;
            end
        end
        last_rdy = erd;
        chk({tag, ".busy"},  busy_out,       32'(m_busy != 0));
        chk({tag, ".grant"}, grant_out,      eg);
        chk({tag, ".addr"},  address_out,    ea);
        chk({tag, ".rd"},    read_out,       er);
        chk({tag, ".wr"},    write_out,      ew);
        chk({tag, ".mask"},  write_mask_out, em);
        chk({tag, ".wval"},  write_value_out, ev);
        chk({tag, ".ready"}, req_ready_out,  erd);
        chk({tag, ".fault"}, req_fault_out,  ef);
        if (erd != 3'b000) begin
            chk({tag, ".rval"}, req_read_value_out, read_value_in);
        end
    endtask

    // Advance the model one clock, using the inputs seen at the edge.
    task automatic tick();
        int n_busy, n_g, n_p, n_wd, idx;
        bit found;
        n_busy = m_busy; n_g = m_g; n_p = m_p; n_wd = m_wd;
        found = 1'b0;
        if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_p + k) % N;
                if (!found && (t_rd[idx] || t_wr[idx])) begin
                    found  = 1'b1;
                    n_g    = idx;
                    n_busy = 1;
                    n_wd   = 0;
                end
            end
        end else if (last_rdy != 3'b000) begin
            n_busy = 0;
            n_p    = (m_g + 1) % N;
        end else if (!(t_rd[m_g] || t_wr[m_g])) begin
            n_busy = 0;
        end else begin
            n_wd = m_wd + 1;
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_g = n_g; m_p = n_p; m_wd = n_wd;
    endtask

    initial begin
        int kind;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        ready_in = 1'b0;
        fault_in = 1'b0;
        read_value_in = '0;
        clear_all();
        model_reset();
        fexp[0] = 3'b001; fexp[1] = 3'b010; fexp[2] = 3'b100; fexp[3] = 3'b001;

        #1;
        settle_check("reset");
        #2 reset = 1'b0;
        tick();

        // all ports hold reads, slave answers in the first bus cycle
        for (int i = 0; i < N; i++) begin
            set_port(i, 1'b1, 1'b0, 32'h100 * (i + 1), 4'h0, 32'h0);
        end
        ready_in = 1'b1;
        read_value_in = 32'hA5A5_0000;
        for (int c = 0; c < 8; c++) begin
            settle_check("fair");
            if (busy_out) gseq.push_back(grant_out);
            tick();
        end
        chk("fair_count", gseq.size(), 4);
        for (int k = 0; k < gseq.size() && k < 4; k++) begin
            chk("fair_order", gseq[k], fexp[k]);
        end
        clear_all();
        ready_in = 1'b0;
        read_value_in = '0;
        settle_check("fair_end");
        tick();

        // single read from port 1, answered one cycle after grant
        set_port(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        settle_check("s_idle");
        tick();
        settle_check("s_bus");
        chk("s_addr", address_out, 32'h0);
        chk("s_grant", grant_out, 3'b010);
        tick();
        ready_in = 1'b1;
        read_value_in = 32'hDEAD_BEEF;
        settle_check("s_rdy");
        chk("s_ready", req_ready_out, 3'b010);
        chk("s_rval", req_read_value_out, 32'hDEAD_BEEF);
        chk("s_fault", req_fault_out, 3'b000);
        tick();
        clear_all();
        ready_in = 1'b0;
        read_value_in = '0;

        // decoder fault on port 0
        set_port(0, 1'b1, 1'b0, 32'h0004_0000, 4'h0, 32'h0);
        settle_check("f_idle");
        tick();
        ready_in = 1'b1;
        fault_in = 1'b1;
        settle_check("f_rdy");
        chk("f_ready", req_ready_out, 3'b001);
        chk("f_fault", req_fault_out, 3'b001);
        tick();
        clear_all();
        ready_in = 1'b0;
        fault_in = 1'b0;
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 1'b0, 32'h40 * i, 4'h0, 32'h0);
        settle_check("f_all");
        tick();
        ready_in = 1'b1;
        settle_check("f_next");
        chk("f_p_adv", grant_out, 3'b010);
        tick();
        clear_all();
        ready_in = 1'b0;

        // watchdog: port 2 writes to a slave that never answers
        set_port(2, 1'b0, 1'b1, 32'h0000_2000, 4'b0001, 32'h0000_0055);
        settle_check("wd_idle0");
        tick();
        for (int c = 0; c < TO; c++) begin
            settle_check("wd");
            chk("wd_mask", write_mask_out, 4'b0001);
            chk("wd_ready", req_ready_out, (c == TO - 1) ? 3'b100 : 3'b000);
            chk("wd_fault", req_fault_out, (c == TO - 1) ? 3'b100 : 3'b000);
            tick();
        end
        clear_all();
        settle_check("wd_idle1");
        chk("wd_busy", busy_out, 1'b0);
        tick();

        // port 1 abandons its request mid-transaction
        set_port(1, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        settle_check("ab_idle0");
        tick();
        settle_check("ab_bus");
        chk("ab_grant", grant_out, 3'b010);
        tick();
        clear_all();
        settle_check("ab_drop");
        chk("ab_noready0", req_ready_out, 3'b000);
        tick();
        settle_check("ab_idle1");
        chk("ab_busy", busy_out, 1'b0);
        chk("ab_noready1", req_ready_out, 3'b000);
        tick();
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 1'b0, 32'h80 * i, 4'h0, 32'h0);
        settle_check("ab_all");
        tick();
        ready_in = 1'b1;
        settle_check("ab_p");
        chk("ab_p_kept", grant_out, 3'b001);
        tick();
        clear_all();
        ready_in = 1'b0;

        // reset while port 2 owns the bus
        set_port(2, 1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0);
        settle_check("rs_idle0");
        tick();
        settle_check("rs_bus");
        chk("rs_grant0", grant_out, 3'b100);
        #1 reset = 1'b1;
        #1;
        chk("rs_busy", busy_out, 1'b0);
        chk("rs_grant", grant_out, 3'b000);
        chk("rs_addr", address_out, 32'h0);
        chk("rs_rd", read_out, 1'b0);
        chk("rs_ready", req_ready_out, 3'b000);
        chk("rs_fault", req_fault_out, 3'b000);
        chk("rs_rval", req_read_value_out, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) set_port(i, 1'b1, 1'b0, 32'hC0 * i, 4'h0, 32'h0);
        settle_check("rs_idle1");
        tick();
        ready_in = 1'b1;
        settle_check("rs_first");
        chk("rs_first_grant", grant_out, 3'b001);
        tick();
        clear_all();
        ready_in = 1'b0;
        last_rdy = '0;

        // random traffic from all ports against a randomly slow slave
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_rdy[i]) begin
                    t_rd[i] = 1'b0;
                    t_wr[i] = 1'b0;
                end else if (!(t_rd[i] || t_wr[i]) && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 3);
                    set_port(i, kind != 1, kind == 1 || kind == 3,
                             $urandom, 4'($urandom), $urandom);
                end
            end
            ready_in = (m_busy != 0) && ($urandom_range(0, 9) < 4);
            fault_in = ready_in && ($urandom_range(0, 4) == 0);
            read_value_in = $urandom;
            settle_check("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_scheduler.md
# mem_bus_scheduler

Round-robin scheduler that shares the single common memory bus (RAM, LEDs, UART, timer, flash) between NUM_PORTS requesters: CPU instruction port, CPU data port, and a future DMA engine. It replaces fixed-priority two-port arbitration and grants one requester at a time. It holds the grant until the addressed slave completes, and adds a bus watchdog that completes hung transactions with a fault. It sits between the requester buses and the address decoder / slave read-value OR tree.

## Interface
- NUM_PORTS, 3, number of requesters; port i occupies bits [i*32 +: 32] of the packed address/value vectors and [i*4 +: 4] of the mask vector
- TIMEOUT, 255, cycles a granted transaction may wait for ready_in before forced fault completion; 0 disables the watchdog
- clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-high reset
- req_address_in  in  32*NUM_PORTS  per-port byte address
- req_read_in  in  NUM_PORTS  per-port read request
- req_write_in  in  NUM_PORTS  per-port write request
- req_write_mask_in  in  4*NUM_PORTS  per-port byte-lane write mask
- req_write_value_in  in  32*NUM_PORTS  per-port write data
- req_read_value_out  out  32  read data, broadcast to all ports, valid only with that port's ready
- req_ready_out  out  NUM_PORTS  one-cycle completion pulse to the granted port
- req_fault_out  out  NUM_PORTS  fault qualifier, valid only with req_ready_out
- address_out, read_out, write_out, write_mask_out (4), write_value_out (32)  out  common-bus request
- read_value_in  in  32  OR'd slave read data
- ready_in  in  1  slave (or decoder fault) completion
- fault_in  in  1  decoder fault
- grant_out  out  NUM_PORTS  one-hot current grant (status)
- busy_out  out  1  high in BUSY

## Operation
- States: IDLE, BUSY. Registers: state, grant index g, round-robin pointer p, watchdog counter wd (width $clog2(TIMEOUT+1), min 1).
- A port is requesting when read_in or write_in is high. A requester holds its address, mask and value stable until it sees its ready.
- IDLE: the bus outputs are all zero, so no slave is selected and write_mask_out=0. If any port is requesting, g is set to the first requesting port at or after p, searching upward modulo NUM_PORTS. The state becomes BUSY and wd is cleared.
- BUSY: the bus outputs mirror port g combinationally. read_out/write_out are forced to 0 for all other ports.
  - If ready_in=1: req_ready_out[g]=1 and req_fault_out[g]=fault_in in the same cycle. read_value_in is passed through. Next: p=g+1 mod NUM_PORTS, state IDLE.
  - Else if TIMEOUT!=0 and wd==TIMEOUT-1: req_ready_out[g]=1 and req_fault_out[g]=1. The bus outputs stay driven this cycle. Next: p=g+1, state IDLE.
  - Else if port g has dropped both read and write (protocol violation): abort. Next: state IDLE, no ready pulse, p unchanged.
  - Else wd increments.
- Only the granted port can ever see ready or fault. All other req_ready_out/req_fault_out bits are 0.
- Simultaneous read and write from one port are passed through unchanged. The slave decides.

## Timing
- Reset values: state=IDLE, p=0, g=0, wd=0. All outputs are 0: the bus outputs, req_ready_out, req_fault_out, req_read_value_out (bus idle → OR tree 0), grant_out, busy_out.
- Arbitration takes 1 cycle. A request first seen in IDLE at cycle N appears on the bus in cycle N+1. The earliest ready pulse is at N+1.
- After completion at cycle M the block is in IDLE at M+1. The next grant drives the bus at M+2, giving a 1-cycle bubble between transactions.
- Back-to-back fairness: with all ports continuously requesting, grants rotate 0,1,2,0,…
- Watchdog: ready_in never arrives, grant driven from cycle N+1 → fault/ready pulse at cycle N+TIMEOUT.
- Ready pulse is exactly one cycle wide. A requester deasserting its request in the cycle after ready does not cause a second grant, because the block is in IDLE.
- Reset asserted mid-BUSY: the outputs clear immediately (asynchronous). No ready is issued and the transaction is lost.

## Test plan
- Single request: port 1 reads 0x00000000 in IDLE, RAM-like slave returns ready one cycle later with 0xDEADBEEF → address_out=0 from cycle N+1, req_ready_out=3'b010 at N+2, read value 0xDEADBEEF, fault 0.
- Fairness: all three ports hold reads, slave ready in the first bus cycle → grant sequence 0,1,2,0 with a completion every 2 cycles, and no port is granted twice before the others.
- Decoder fault: port 0 reads 0x00040000, ready_in=fault_in=1 the same cycle → req_ready_out[0]=1, req_fault_out[0]=1, p advances to 1.
- Watchdog: TIMEOUT=4, port 2 writes mask 4'b0001 to a slave that never answers → write_mask_out=4'b0001 for 4 cycles, then ready and fault pulse on port 2, IDLE.
- Abort and reset: port 1 drops its request while BUSY → IDLE next cycle, no ready, p unchanged. Separately, reset asserted mid-BUSY → all outputs 0 in the same cycle, and the first grant after release goes to port 0.
